// File: rtl/booth_acc.sv
// booth_acc: collects a programmable-length burst of signed products into a signed sum.
// Optional build macro BOOTH_ACC_SAT_EN selects saturating accumulation; otherwise the sum wraps.
module booth_acc #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              prod_valid_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic              prod_ready_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_s;
    logic [LEN_W:0]     cnt_r;
    logic [LEN_W:0]     cnt_s;
    logic [LEN_W:0]     len_r;
    logic [LEN_W:0]     len_s;
    logic               ovf_r;
    logic               ovf_s;
    logic               accept_s;
    logic [LEN_W:0]     cnt_inc_s;
    logic [ACC_W:0]     wide_s;
    logic               add_ovf_s;

    // One guard bit above the accumulator exposes signed overflow as a top-bit mismatch.
    function automatic logic [ACC_W:0] wide_add(input logic [ACC_W-1:0] acc,
                                                input logic [PROD_W-1:0] prod);
        logic [ACC_W:0] acc_x;
        logic [ACC_W:0] prod_x;
        acc_x  = {acc[ACC_W-1], acc};
        prod_x = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        return acc_x + prod_x;
    endfunction

    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] wide,
                                                  input logic ovf);
        logic [ACC_W-1:0] res;
`ifdef BOOTH_ACC_SAT_EN
        if (ovf) begin
            // The guard bit carries the true sign of the unclamped result.
            res = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            res = wide[ACC_W-1:0];
        end
`else
        res = ovf ? wide[ACC_W-1:0] : wide[ACC_W-1:0];
`endif
        return res;
    endfunction

    assign accept_s  = prod_valid_i && (state_r == ST_ACC);
    assign cnt_inc_s = cnt_r + {{LEN_W{1'b0}}, 1'b1};
    assign wide_s    = wide_add(acc_r, prod_i);
    assign add_ovf_s = wide_s[ACC_W] ^ wide_s[ACC_W-1];

    // Next-state and datapath update for the burst FSM.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
        ovf_s   = ovf_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    len_s   = (len_i == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}}
                                                       : {1'b0, len_i};
                    acc_s   = {ACC_W{1'b0}};
                    cnt_s   = {(LEN_W+1){1'b0}};
                    ovf_s   = 1'b0;
                    state_s = ST_ACC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s) begin
                    acc_s = fold_sum(wide_s, add_ovf_s);
                    cnt_s = cnt_inc_s;
                    ovf_s = ovf_r | add_ovf_s;
                    if (cnt_inc_s == len_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DONE: begin
                if (sum_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; rst overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {(LEN_W+1){1'b0}};
            len_r   <= {(LEN_W+1){1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            ovf_r   <= ovf_s;
        end
    end

    assign prod_ready_o = (state_r == ST_ACC);
    assign sum_valid_o  = (state_r == ST_DONE);
    assign busy_o       = (state_r != ST_IDLE);
    assign sum_o        = acc_r;
    assign ovf_o        = ovf_r;

endmodule
